// File: rtl/j1p.sv
// J1-style stack processor: 16-bit instructions, data/return stacks in registers,
// stalling IO handshake, level interrupt and a fetch cycle in the upper code half.
module j1p #(
   parameter int unsigned       WIDTH   = 16,
   parameter int unsigned       CODE_AW = 13,
   parameter int unsigned       DDEPTH  = 16,
   parameter int unsigned       RDEPTH  = 16,
   parameter logic [CODE_AW-1:0] IRQ_VEC = {{(CODE_AW-1){1'b1}}, 1'b0}
) (
   input  logic               clk,
   input  logic               resetq,
   input  logic [15:0]        insn_from_memory,
   output logic [CODE_AW-1:0] code_addr,
   output logic [WIDTH-1:0]   mem_addr,
   output logic [WIDTH-1:0]   dout,
   output logic               mem_wr,
   output logic               io_wr,
   output logic               io_rd,
   input  logic [WIDTH-1:0]   io_din,
   input  logic               io_ready,
   input  logic               interrupt,
   output logic               irq_ack,
   output logic               dstk_err
);

   localparam int unsigned DAW = $clog2(DDEPTH);
   localparam int unsigned RAW = $clog2(RDEPTH);

   logic [CODE_AW-1:0] r_pc;
   logic [WIDTH-1:0]   r_st0;
   logic [DAW-1:0]     r_dsp;
   logic [RAW-1:0]     r_rsp;
   logic               r_dstk_err;
   logic               r_booted;
   logic [WIDTH-1:0]   r_dstack [DDEPTH];
   logic [WIDTH-1:0]   r_rstack [RDEPTH];

   logic [15:0]        w_insn;
   logic [WIDTH-1:0]   w_st1;
   logic [WIDTH-1:0]   w_rst0;
   logic [CODE_AW-1:0] w_pc_plus_1;
   logic [CODE_AW-1:0] w_target;
   logic [CODE_AW-1:0] w_ret;
   logic [2:0]         w_func;
   logic [3:0]         w_op;
   logic               w_is_alu;
   logic               w_fetch;
   logic               w_stall;
   logic               w_irq_take;
   logic [WIDTH-1:0]   w_alu;

   logic [CODE_AW-1:0] w_pc_n;
   logic [WIDTH-1:0]   w_st0_n;
   logic [1:0]         w_dd;
   logic [1:0]         w_rd;
   logic               w_tn;
   logic               w_rwe;
   logic [WIDTH-1:0]   w_rdat;
   logic               w_irq_ack;
   logic               w_strobe_ok;
   logic               w_dwe;
   logic [DAW-1:0]     w_dsp_n;
   logic [RAW-1:0]     w_rsp_n;
   logic               w_derr;

   assign w_insn      = insn_from_memory;
   assign w_st1       = r_dstack[r_dsp];
   assign w_rst0      = r_rstack[r_rsp];
   assign w_pc_plus_1 = r_pc + CODE_AW'(1);
   assign w_target    = CODE_AW'(w_insn[12:0]);
   assign w_ret       = w_rst0[CODE_AW:1];
   assign w_func      = w_insn[6:4];
   assign w_op        = w_insn[11:8];
   assign w_is_alu    = (w_insn[15:13] == 3'b011);
   assign w_fetch     = r_pc[CODE_AW-1];

   // IO access not yet acknowledged freezes the whole machine
   assign w_stall    = r_booted & ~w_fetch & w_is_alu &
                       ((w_func == 3'd4) | (w_func == 3'd5)) & ~io_ready;
   assign w_irq_take = r_booted & interrupt & ~w_stall;

   // ALU result; compares use N as left operand
   always_comb begin
      w_alu = r_st0;
      case (w_op)
         4'd0:    w_alu = r_st0;
         4'd1:    w_alu = w_st1;
         4'd2:    w_alu = r_st0 + w_st1;
         4'd3:    w_alu = r_st0 & w_st1;
         4'd4:    w_alu = r_st0 | w_st1;
         4'd5:    w_alu = r_st0 ^ w_st1;
         4'd6:    w_alu = ~r_st0;
         4'd7:    w_alu = {WIDTH{w_st1 == r_st0}};
         4'd8:    w_alu = {WIDTH{$signed(w_st1) < $signed(r_st0)}};
         4'd9:    w_alu = {r_st0[WIDTH-1], r_st0[WIDTH-1:1]};
         4'd10:   w_alu = {r_st0[WIDTH-2:0], 1'b0};
         4'd11:   w_alu = w_rst0;
         4'd12:   w_alu = w_st1 - r_st0;
         4'd13:   w_alu = io_din;
         4'd14:   w_alu = WIDTH'(r_dsp);
         default: w_alu = {WIDTH{w_st1 < r_st0}};
      endcase
   end

   // Next-state decode; priority: reboot, stall, interrupt, fetch, instruction
   always_comb begin
      w_pc_n      = w_pc_plus_1;
      w_st0_n     = r_st0;
      w_dd        = 2'b00;
      w_rd        = 2'b00;
      w_tn        = 1'b0;
      w_rwe       = 1'b0;
      w_rdat      = r_st0;
      w_irq_ack   = 1'b0;
      w_strobe_ok = 1'b0;
      if (!r_booted) begin
         w_pc_n = '0;
      end else if (w_stall) begin
         w_pc_n      = r_pc;
         w_strobe_ok = 1'b1;
      end else if (w_irq_take) begin
         w_pc_n    = IRQ_VEC;
         w_rd      = 2'b01;
         w_rwe     = 1'b1;
         w_rdat    = WIDTH'({r_pc, 1'b0});
         w_irq_ack = 1'b1;
      end else if (w_fetch) begin
         w_st0_n = WIDTH'(w_insn);
         w_dd    = 2'b01;
         w_rd    = 2'b11;
         w_pc_n  = w_ret;
      end else if (w_insn[15]) begin
         w_st0_n = WIDTH'(w_insn[14:0]);
         w_dd    = 2'b01;
      end else begin
         case (w_insn[14:13])
            2'b00: w_pc_n = w_target;
            2'b01: begin
               w_dd    = 2'b11;
               w_st0_n = w_st1;
               if (r_st0 == '0) w_pc_n = w_target;
            end
            2'b10: begin
               w_rd   = 2'b01;
               w_rwe  = 1'b1;
               w_rdat = WIDTH'({w_pc_plus_1, 1'b0});
               w_pc_n = w_target;
            end
            default: begin
               w_st0_n     = w_alu;
               w_dd        = w_insn[1:0];
               w_rd        = w_insn[3:2];
               w_tn        = (w_func == 3'd1);
               w_rwe       = (w_func == 3'd2);
               w_strobe_ok = 1'b1;
               if (w_insn[7]) w_pc_n = w_ret;
            end
         endcase
      end
   end

   assign w_dsp_n = r_dsp + DAW'($signed(w_dd));
   assign w_rsp_n = r_rsp + RAW'($signed(w_rd));
   assign w_dwe   = w_tn | (w_dd == 2'b01);
   assign w_derr  = ((w_dd == 2'b01) & (r_dsp == DAW'(DDEPTH - 1))) |
                    ((w_dd == 2'b11) & (r_dsp == '0)) |
                    ((w_dd == 2'b10) & (r_dsp < DAW'(2)));

   assign code_addr = resetq ? w_pc_n : '0;
   assign mem_addr  = r_st0;
   assign dout      = w_st1;
   assign mem_wr    = resetq & w_strobe_ok & (w_func == 3'd3);
   assign io_wr     = resetq & w_strobe_ok & (w_func == 3'd4);
   assign io_rd     = resetq & w_strobe_ok & (w_func == 3'd5);
   assign irq_ack   = resetq & w_irq_ack;
   assign dstk_err  = r_dstk_err;

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         r_pc       <= '0;
         r_st0      <= '0;
         r_dsp      <= '0;
         r_rsp      <= '0;
         r_dstk_err <= 1'b0;
         r_booted   <= 1'b0;
      end else begin
         r_booted <= 1'b1;
         r_pc     <= w_pc_n;
         r_st0    <= w_st0_n;
         r_dsp    <= w_dsp_n;
         r_rsp    <= w_rsp_n;
         if (w_derr) r_dstk_err <= 1'b1;
      end
   end

   // Stack storage is not reset; writes are idle while not booted
   always_ff @(posedge clk) begin
      if (w_dwe) r_dstack[w_dsp_n] <= r_st0;
      if (w_rwe) r_rstack[w_rsp_n] <= w_rdat;
   end

endmodule
